// File: rtl/ram_wrapper_pkg.sv
// ---------------------------------------------------------------------------
// ram_wrapper_pkg
// Shared helpers for the banked RAM wrapper: ceiling-log2, bank geometry
// derivation and the address split into bank index and bank word address.
// The split functions work on a zero-extended 32-bit address so they can be
// used for any AWIDTH up to 31.
// ---------------------------------------------------------------------------
package ram_wrapper_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int bank_bits(input int num_banks);
        return clog2(num_banks);
    endfunction

    function automatic int bank_depth(input int num_words, input int num_banks);
        return num_words / num_banks;
    endfunction

    // A one-word bank still needs a 1-bit address bus.
    function automatic int bank_addr_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    // Bank select: low bits when interleaved, top bits otherwise.
    function automatic logic [31:0] bank_index(
        input logic [31:0] addr,
        input int          awidth,
        input int          bbits,
        input bit          interleave
    );
        logic [31:0] mask;
        if (bbits == 0) begin
            return '0;
        end
        mask = (32'd1 << bbits) - 32'd1;
        if (interleave) begin
            return addr & mask;
        end
        return (addr >> (awidth - bbits)) & mask;
    endfunction

    // Word address inside the bank: whatever bits are not the bank index,
    // folded modulo the bank depth so out-of-range addresses wrap silently.
    function automatic logic [31:0] bank_word(
        input logic [31:0] addr,
        input int          awidth,
        input int          bbits,
        input bit          interleave,
        input int          depth
    );
        logic [31:0] word;
        if (interleave) begin
            word = addr >> bbits;
        end else begin
            word = addr & ((32'd1 << (awidth - bbits)) - 32'd1);
        end
        return word % $unsigned(depth);
    endfunction

endpackage

// File: rtl/dpram.sv
// ---------------------------------------------------------------------------
// dpram
// Simple true dual-port RAM with registered reads. Read data for a port only
// changes when that port's read enable is high. Contents are never reset.
// Ports: clk; we_x/re_x enables, addr_x word address, wdata_x write data,
// rdata_x registered read data (x = a, b).
// ---------------------------------------------------------------------------
module dpram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic          re_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic [DW-1:0] rdata_a,
    input  logic          we_b,
    input  logic          re_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [DEPTH];

    // The wrapper never issues two writes to the same word in one cycle, and
    // it never relies on the read-during-write result.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
        if (we_b) begin
            mem[addr_b] <= wdata_b;
        end
        if (re_a) begin
            rdata_a <= mem[addr_a];
        end
        if (re_b) begin
            rdata_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/ram_port_ctrl.sv
// ---------------------------------------------------------------------------
// ram_port_ctrl
// Read-return pipeline for one wrapper port. A read accepted in cycle t
// returns in t+1 (t+2 with OUT_REG). The return is either the addressed
// bank's read data or, when a write hit the same word in the issue cycle,
// the registered bypass data. The last return is held until the next one.
// Ports: clk, reset; rden (already reset-gated), bank index of the read,
// bypass_hit/bypass_data captured with the read; bank_rdata from every bank;
// out (held read data) and valid (one-cycle return pulse).
// ---------------------------------------------------------------------------
module ram_port_ctrl
    import ram_wrapper_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int NUM_BANKS = 2,
    parameter int BIW       = 1,
    parameter int OUT_REG   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rden,
    input  logic [BIW-1:0]    bank,
    input  logic              bypass_hit,
    input  logic [DWIDTH-1:0] bypass_data,
    input  logic [DWIDTH-1:0] bank_rdata [NUM_BANKS],
    output logic [DWIDTH-1:0] out,
    output logic              valid
);

    logic              valid1_reg;
    logic [BIW-1:0]    bank1_reg;
    logic              hit1_reg;
    logic [DWIDTH-1:0] bypass1_reg;
    logic [DWIDTH-1:0] hold_reg;

    logic [DWIDTH-1:0] ret_data;
    logic              ret_valid;
    logic [DWIDTH-1:0] stage_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid1_reg  <= 1'b0;
            bank1_reg   <= '0;
            hit1_reg    <= 1'b0;
            bypass1_reg <= '0;
            hold_reg    <= '0;
        end else begin
            valid1_reg  <= rden;
            bank1_reg   <= bank;
            hit1_reg    <= bypass_hit;
            bypass1_reg <= bypass_data;
            if (valid1_reg) begin
                hold_reg <= ret_data;
            end
        end
    end

    assign ret_data = hit1_reg ? bypass1_reg : bank_rdata[bank1_reg];

    // A return that lands in a reset cycle is dropped, so no valid pulse
    // escapes for a read issued just before reset.
    assign ret_valid  = valid1_reg & ~reset;
    assign stage_data = ret_valid ? ret_data : hold_reg;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DWIDTH-1:0] out_reg;
            logic              valid_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_reg   <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    out_reg   <= stage_data;
                    valid_reg <= ret_valid;
                end
            end

            assign out   = out_reg;
            assign valid = valid_reg & ~reset;
        end else begin : g_no_out_reg
            assign out   = stage_data;
            assign valid = ret_valid;
        end
    endgenerate

endmodule

// File: rtl/banked_ram_wrapper.sv
// ---------------------------------------------------------------------------
// banked_ram_wrapper
// Dual-port RAM built from NUM_BANKS dpram banks behind two independent
// read/write ports. Reads are write-first against both ports, read data is
// held between returns, and same-word A/B writes resolve in favour of A and
// raise a sticky collision flag.
// Ports: clk, reset (sync, active-high); address_x, rden_x, wren_x, data_x
// per port (x = a, b); out_x held read data, valid_x return pulse;
// collision sticky flag, clear_collision clears it (a new collision wins).
// ---------------------------------------------------------------------------
module banked_ram_wrapper
    import ram_wrapper_pkg::*;
#(
    parameter int AWIDTH     = 10,
    parameter int NUM_WORDS  = 1024,
    parameter int DWIDTH     = 32,
    parameter int NUM_BANKS  = 2,
    parameter int INTERLEAVE = 1,
    parameter int OUT_REG    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] address_a,
    input  logic              rden_a,
    input  logic              wren_a,
    input  logic [DWIDTH-1:0] data_a,
    output logic [DWIDTH-1:0] out_a,
    output logic              valid_a,
    input  logic [AWIDTH-1:0] address_b,
    input  logic              rden_b,
    input  logic              wren_b,
    input  logic [DWIDTH-1:0] data_b,
    output logic [DWIDTH-1:0] out_b,
    output logic              valid_b,
    output logic              collision,
    input  logic              clear_collision
);

    localparam int BBITS = bank_bits(NUM_BANKS);
    localparam int DEPTH = bank_depth(NUM_WORDS, NUM_BANKS);
    localparam int BAW   = bank_addr_width(DEPTH);
    localparam int BIW   = (BBITS > 0) ? BBITS : 1;
    localparam bit ILV   = (INTERLEAVE != 0);

    // ---------------- address decode ----------------
    logic [31:0]    addr_a_ext;
    logic [31:0]    addr_b_ext;
    logic [BIW-1:0] bank_a;
    logic [BIW-1:0] bank_b;
    logic [BAW-1:0] word_a;
    logic [BAW-1:0] word_b;

    assign addr_a_ext = 32'(address_a);
    assign addr_b_ext = 32'(address_b);
    assign bank_a     = BIW'(bank_index(addr_a_ext, AWIDTH, BBITS, ILV));
    assign bank_b     = BIW'(bank_index(addr_b_ext, AWIDTH, BBITS, ILV));
    assign word_a     = BAW'(bank_word(addr_a_ext, AWIDTH, BBITS, ILV, DEPTH));
    assign word_b     = BAW'(bank_word(addr_b_ext, AWIDTH, BBITS, ILV, DEPTH));

    // Compare physical locations so that wrapped aliases are treated as the
    // same word both for forwarding and for collision suppression.
    logic same_word;
    assign same_word = (bank_a == bank_b) && (word_a == word_b);

    // ---------------- request gating and collision ----------------
    logic re_a;
    logic re_b;
    logic we_a;
    logic we_b_req;
    logic we_b;
    logic coll_set;
    logic collision_reg;

    assign re_a     = rden_a & ~reset;
    assign re_b     = rden_b & ~reset;
    assign we_a     = wren_a & ~reset;
    assign we_b_req = wren_b & ~reset;
    assign coll_set = we_a & we_b_req & same_word;
    assign we_b     = we_b_req & ~coll_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            collision_reg <= 1'b0;
        end else if (coll_set) begin
            collision_reg <= 1'b1;
        end else if (clear_collision) begin
            collision_reg <= 1'b0;
        end
    end

    assign collision = collision_reg;

    // ---------------- write-first bypass selection ----------------
    // Port A's own write always targets its read address; otherwise a B
    // write to the same word forwards. Port B sees A first so that a
    // double write returns data_a.
    logic              hit_a;
    logic              hit_b;
    logic [DWIDTH-1:0] bypass_data_a;
    logic [DWIDTH-1:0] bypass_data_b;

    assign hit_a         = we_a | (we_b_req & same_word);
    assign bypass_data_a = we_a ? data_a : data_b;
    assign hit_b         = (we_a & same_word) | we_b_req;
    assign bypass_data_b = (we_a & same_word) ? data_a : data_b;

    // ---------------- banks ----------------
    logic [DWIDTH-1:0] rdata_a [NUM_BANKS];
    logic [DWIDTH-1:0] rdata_b [NUM_BANKS];

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic sel_a;
            logic sel_b;

            assign sel_a = (bank_a == BIW'(gi));
            assign sel_b = (bank_b == BIW'(gi));

            dpram #(
                .DEPTH (DEPTH),
                .AW    (BAW),
                .DW    (DWIDTH)
            ) u_dpram (
                .clk     (clk),
                .we_a    (we_a & sel_a),
                .re_a    (re_a & sel_a),
                .addr_a  (word_a),
                .wdata_a (data_a),
                .rdata_a (rdata_a[gi]),
                .we_b    (we_b & sel_b),
                .re_b    (re_b & sel_b),
                .addr_b  (word_b),
                .wdata_b (data_b),
                .rdata_b (rdata_b[gi])
            );
        end
    endgenerate

    // ---------------- per-port return pipelines ----------------
    ram_port_ctrl #(
        .DWIDTH    (DWIDTH),
        .NUM_BANKS (NUM_BANKS),
        .BIW       (BIW),
        .OUT_REG   (OUT_REG)
    ) u_port_a (
        .clk         (clk),
        .reset       (reset),
        .rden        (re_a),
        .bank        (bank_a),
        .bypass_hit  (hit_a),
        .bypass_data (bypass_data_a),
        .bank_rdata  (rdata_a),
        .out         (out_a),
        .valid       (valid_a)
    );

    ram_port_ctrl #(
        .DWIDTH    (DWIDTH),
        .NUM_BANKS (NUM_BANKS),
        .BIW       (BIW),
        .OUT_REG   (OUT_REG)
    ) u_port_b (
        .clk         (clk),
        .reset       (reset),
        .rden        (re_b),
        .bank        (bank_b),
        .bypass_hit  (hit_b),
        .bypass_data (bypass_data_b),
        .bank_rdata  (rdata_b),
        .out         (out_b),
        .valid       (valid_b)
    );

endmodule

// File: tb/tb_banked_ram_wrapper.sv
// ---------------------------------------------------------------------------
// tb_banked_ram_wrapper
// Directed bench for banked_ram_wrapper. Two 32-bit, 4-bank instances
// (interleaved and block-banked) share one stimulus set; a 64-bit, single
// bank instance with the output register has its own stimulus. Inputs are
// driven just after the falling edge and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_banked_ram_wrapper;

    localparam int RN = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- narrow pair (dut 0: interleaved, dut 1: block) -------
    logic        reset;
    logic [9:0]  address_a, address_b;
    logic        rden_a, rden_b, wren_a, wren_b, clear_collision;
    logic [31:0] data_a, data_b;
    logic [31:0] n_out_a [2];
    logic [31:0] n_out_b [2];
    logic        n_valid_a [2];
    logic        n_valid_b [2];
    logic        n_coll [2];

    banked_ram_wrapper #(
        .AWIDTH(10), .NUM_WORDS(1024), .DWIDTH(32),
        .NUM_BANKS(4), .INTERLEAVE(1), .OUT_REG(0)
    ) dut_ilv (
        .clk(clk), .reset(reset),
        .address_a(address_a), .rden_a(rden_a), .wren_a(wren_a), .data_a(data_a),
        .out_a(n_out_a[0]), .valid_a(n_valid_a[0]),
        .address_b(address_b), .rden_b(rden_b), .wren_b(wren_b), .data_b(data_b),
        .out_b(n_out_b[0]), .valid_b(n_valid_b[0]),
        .collision(n_coll[0]), .clear_collision(clear_collision)
    );

    banked_ram_wrapper #(
        .AWIDTH(10), .NUM_WORDS(1024), .DWIDTH(32),
        .NUM_BANKS(4), .INTERLEAVE(0), .OUT_REG(0)
    ) dut_blk (
        .clk(clk), .reset(reset),
        .address_a(address_a), .rden_a(rden_a), .wren_a(wren_a), .data_a(data_a),
        .out_a(n_out_a[1]), .valid_a(n_valid_a[1]),
        .address_b(address_b), .rden_b(rden_b), .wren_b(wren_b), .data_b(data_b),
        .out_b(n_out_b[1]), .valid_b(n_valid_b[1]),
        .collision(n_coll[1]), .clear_collision(clear_collision)
    );

    // ---------------- wide instance ----------------
    logic        w_reset;
    logic [9:0]  w_address_a, w_address_b;
    logic        w_rden_a, w_rden_b, w_wren_a, w_wren_b, w_clear_collision;
    logic [63:0] w_data_a, w_data_b, w_out_a, w_out_b;
    logic        w_valid_a, w_valid_b, w_collision;

    banked_ram_wrapper #(
        .AWIDTH(10), .NUM_WORDS(1024), .DWIDTH(64),
        .NUM_BANKS(1), .INTERLEAVE(1), .OUT_REG(1)
    ) dut_wide (
        .clk(clk), .reset(w_reset),
        .address_a(w_address_a), .rden_a(w_rden_a), .wren_a(w_wren_a), .data_a(w_data_a),
        .out_a(w_out_a), .valid_a(w_valid_a),
        .address_b(w_address_b), .rden_b(w_rden_b), .wren_b(w_wren_b), .data_b(w_data_b),
        .out_b(w_out_b), .valid_b(w_valid_b),
        .collision(w_collision), .clear_collision(w_clear_collision)
    );

    logic [63:0] w_model [8];
    logic [63:0] w_last_a, w_last_b;

    task automatic idle();
        rden_a = 1'b0; rden_b = 1'b0; wren_a = 1'b0; wren_b = 1'b0;
        clear_collision = 1'b0;
    endtask

    task automatic w_idle();
        w_rden_a = 1'b0; w_rden_b = 1'b0; w_wren_a = 1'b0; w_wren_b = 1'b0;
        w_clear_collision = 1'b0;
    endtask

    // ---------------- 1: reset with a read in flight ----------------
    task automatic test_reset();
        @(negedge clk); idle();
        address_a = 10'h007; address_b = 10'h007; wren_a = 1'b1; wren_b = 1'b1;
        data_a = 32'h11111111; data_b = 32'h22222222;
        @(negedge clk); idle(); address_a = 10'h007; rden_a = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_coll[d] !== 1'b1) begin errors++; $display("FAIL reset_setup_coll dut%0d got=%b exp=1", d, n_coll[d]); end
        end
        // This cycle's rden_a is the read that reset will catch in flight.
        @(negedge clk); idle(); rden_a = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_valid_a[d] !== 1'b1) begin errors++; $display("FAIL reset_setup_valid dut%0d got=%b exp=1", d, n_valid_a[d]); end
            checks++; if (n_out_a[d] !== 32'h11111111) begin errors++; $display("FAIL reset_setup_data dut%0d got=%h exp=11111111", d, n_out_a[d]); end
        end
        $display("[reset] setup read 0x007 -> %h / %h", n_out_a[0], n_out_a[1]);
        @(negedge clk); idle(); reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_valid_a[d] !== 1'b0) begin errors++; $display("FAIL reset_inflight_valid dut%0d got=%b exp=0", d, n_valid_a[d]); end
        end
        @(negedge clk); reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_valid_a[d] !== 1'b0) begin errors++; $display("FAIL reset_after_valid_a dut%0d got=%b exp=0", d, n_valid_a[d]); end
            checks++; if (n_valid_b[d] !== 1'b0) begin errors++; $display("FAIL reset_after_valid_b dut%0d got=%b exp=0", d, n_valid_b[d]); end
            checks++; if (n_out_a[d] !== 32'h0) begin errors++; $display("FAIL reset_out_a dut%0d got=%h exp=0", d, n_out_a[d]); end
            checks++; if (n_out_b[d] !== 32'h0) begin errors++; $display("FAIL reset_out_b dut%0d got=%h exp=0", d, n_out_b[d]); end
            checks++; if (n_coll[d] !== 1'b0) begin errors++; $display("FAIL reset_coll dut%0d got=%b exp=0", d, n_coll[d]); end
        end
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_valid_a[d] !== 1'b0) begin errors++; $display("FAIL reset_late_valid dut%0d got=%b exp=0", d, n_valid_a[d]); end
        end
        checks++; if (w_valid_a !== 1'b0 || w_valid_b !== 1'b0) begin errors++; $display("FAIL reset_wide_valid got=%b%b exp=00", w_valid_a, w_valid_b); end
        checks++; if (w_out_a !== 64'h0 || w_out_b !== 64'h0) begin errors++; $display("FAIL reset_wide_out got=%h/%h exp=0", w_out_a, w_out_b); end
        checks++; if (w_collision !== 1'b0) begin errors++; $display("FAIL reset_wide_coll got=%b exp=0", w_collision); end
        $display("[reset] after reset out_a=%h/%h coll=%b/%b", n_out_a[0], n_out_a[1], n_coll[0], n_coll[1]);
    endtask

    // ---------------- 2: read and hold ----------------
    task automatic test_hold();
        @(negedge clk); idle(); wren_a = 1'b1; address_a = 10'h005; data_a = 32'hDEADBEEF;
        @(negedge clk); idle();
        @(negedge clk); idle(); rden_b = 1'b1; address_b = 10'h005;
        @(negedge clk); idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_valid_b[d] !== 1'b1) begin errors++; $display("FAIL hold_valid dut%0d got=%b exp=1", d, n_valid_b[d]); end
            checks++; if (n_out_b[d] !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_read dut%0d got=%h exp=deadbeef", d, n_out_b[d]); end
        end
        $display("[hold] read B 0x005 -> %h / %h", n_out_b[0], n_out_b[1]);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); idle();
            if (k % 2 == 1) begin
                wren_a = 1'b1; address_a = 10'h005; data_a = 32'h1000_0000 + 32'(k);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++; if (n_valid_b[d] !== 1'b0) begin errors++; $display("FAIL hold_idle_valid dut%0d cyc%0d got=%b exp=0", d, k, n_valid_b[d]); end
                checks++; if (n_out_b[d] !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_stable dut%0d cyc%0d got=%h exp=deadbeef", d, k, n_out_b[d]); end
            end
            $display("[hold] cycle %0d wren_a=%b out_b=%h / %h", k, wren_a, n_out_b[0], n_out_b[1]);
        end
    endtask

    // ---------------- 3: write-first forwarding ----------------
    task automatic test_forward();
        // A reads what B writes in the same cycle.
        @(negedge clk); idle();
        rden_a = 1'b1; address_a = 10'h010; wren_b = 1'b1; address_b = 10'h010; data_b = 32'h12345678;
        // A reads its own write; B reads a word A writes is covered next.
        @(negedge clk); idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_out_a[d] !== 32'h12345678 || n_valid_a[d] !== 1'b1) begin errors++; $display("FAIL fwd_b_to_a dut%0d got=%h v=%b exp=12345678", d, n_out_a[d], n_valid_a[d]); end
        end
        $display("[fwd] A read 0x010 during B write -> %h / %h", n_out_a[0], n_out_a[1]);
        rden_a = 1'b1; wren_a = 1'b1; address_a = 10'h020; data_a = 32'hCAFEF00D;
        rden_b = 1'b1; address_b = 10'h010;
        @(negedge clk); idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_out_a[d] !== 32'hCAFEF00D) begin errors++; $display("FAIL fwd_own dut%0d got=%h exp=cafef00d", d, n_out_a[d]); end
            checks++; if (n_out_b[d] !== 32'h12345678) begin errors++; $display("FAIL fwd_stored dut%0d got=%h exp=12345678", d, n_out_b[d]); end
        end
        $display("[fwd] A own write 0x020 -> %h, B read 0x010 -> %h", n_out_a[0], n_out_b[0]);
        rden_b = 1'b1; address_b = 10'h030; wren_a = 1'b1; address_a = 10'h030; data_a = 32'h0BADF00D;
        @(negedge clk); idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_out_b[d] !== 32'h0BADF00D) begin errors++; $display("FAIL fwd_a_to_b dut%0d got=%h exp=0badf00d", d, n_out_b[d]); end
        end
        $display("[fwd] B read 0x030 during A write -> %h / %h", n_out_b[0], n_out_b[1]);
    endtask

    // ---------------- 4: collision ----------------
    task automatic test_collision();
        @(negedge clk); idle();
        wren_a = 1'b1; wren_b = 1'b1; address_a = 10'h3FF; address_b = 10'h3FF;
        data_a = 32'hAAAA0000; data_b = 32'h0000BBBB; rden_b = 1'b1;
        @(negedge clk); idle(); rden_a = 1'b1; address_a = 10'h3FF;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_coll[d] !== 1'b1) begin errors++; $display("FAIL coll_set dut%0d got=%b exp=1", d, n_coll[d]); end
            checks++; if (n_out_b[d] !== 32'hAAAA0000) begin errors++; $display("FAIL coll_fwd dut%0d got=%h exp=aaaa0000", d, n_out_b[d]); end
        end
        @(negedge clk); idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_out_a[d] !== 32'hAAAA0000) begin errors++; $display("FAIL coll_stored dut%0d got=%h exp=aaaa0000", d, n_out_a[d]); end
        end
        $display("[coll] double write 0x3FF: fwd=%h stored=%h coll=%b", n_out_b[0], n_out_a[0], n_coll[0]);
        @(negedge clk); idle(); clear_collision = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_coll[d] !== 1'b1) begin errors++; $display("FAIL coll_sticky dut%0d got=%b exp=1", d, n_coll[d]); end
        end
        @(negedge clk); idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_coll[d] !== 1'b0) begin errors++; $display("FAIL coll_clear dut%0d got=%b exp=0", d, n_coll[d]); end
        end
        $display("[coll] cleared coll=%b/%b", n_coll[0], n_coll[1]);
        @(negedge clk); idle();
        wren_a = 1'b1; wren_b = 1'b1; address_a = 10'h3FF; address_b = 10'h3FF; clear_collision = 1'b1;
        @(negedge clk); idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_coll[d] !== 1'b1) begin errors++; $display("FAIL coll_set_wins dut%0d got=%b exp=1", d, n_coll[d]); end
        end
        $display("[coll] set+clear same cycle coll=%b/%b", n_coll[0], n_coll[1]);
        clear_collision = 1'b1;
        // Different words in the same bank (both layouts) both land.
        @(negedge clk); idle();
        wren_a = 1'b1; address_a = 10'h100; data_a = 32'h01010101;
        wren_b = 1'b1; address_b = 10'h104; data_b = 32'h02020202;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_coll[d] !== 1'b0) begin errors++; $display("FAIL coll_reclear dut%0d got=%b exp=0", d, n_coll[d]); end
        end
        @(negedge clk); idle(); rden_a = 1'b1; address_a = 10'h100; rden_b = 1'b1; address_b = 10'h104;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_coll[d] !== 1'b0) begin errors++; $display("FAIL coll_false dut%0d got=%b exp=0", d, n_coll[d]); end
        end
        @(negedge clk); idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_out_a[d] !== 32'h01010101 || n_out_b[d] !== 32'h02020202) begin errors++; $display("FAIL coll_same_bank dut%0d got=%h/%h exp=01010101/02020202", d, n_out_a[d], n_out_b[d]); end
        end
        $display("[coll] same-bank writes 0x100/0x104 -> %h / %h", n_out_a[0], n_out_b[0]);
    endtask

    // ---------------- 5: full sweep, both bank layouts ----------------
    task automatic test_banking();
        for (int i = 0; i < 512; i++) begin
            @(negedge clk); idle();
            wren_a = 1'b1; address_a = 10'(2 * i);     data_a = 32'(2 * i);
            wren_b = 1'b1; address_b = 10'(2 * i + 1); data_b = 32'(2 * i + 1);
        end
        $display("[bank] wrote 1024 words, data = address");
        for (int k = 0; k <= 1024; k++) begin
            @(negedge clk); idle();
            if (k < 1024) begin
                rden_a = 1'b1; address_a = 10'(k);
                rden_b = 1'b1; address_b = 10'(1023 - k);
            end
            #1;
            if (k > 0) begin
                for (int d = 0; d < 2; d++) begin
                    checks++; if (n_valid_a[d] !== 1'b1 || n_out_a[d] !== 32'(k - 1)) begin errors++; $display("FAIL bank_a dut%0d idx%0d got=%h v=%b exp=%h", d, k - 1, n_out_a[d], n_valid_a[d], 32'(k - 1)); end
                    checks++; if (n_valid_b[d] !== 1'b1 || n_out_b[d] !== 32'(1024 - k)) begin errors++; $display("FAIL bank_b dut%0d idx%0d got=%h v=%b exp=%h", d, k - 1, n_out_b[d], n_valid_b[d], 32'(1024 - k)); end
                end
                $display("[bank] read %0d: A=%h/%h B=%h/%h", k - 1, n_out_a[0], n_out_a[1], n_out_b[0], n_out_b[1]);
            end
        end
        @(negedge clk); idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (n_valid_a[d] !== 1'b0 || n_valid_b[d] !== 1'b0) begin errors++; $display("FAIL bank_drain dut%0d got=%b%b exp=00", d, n_valid_a[d], n_valid_b[d]); end
        end
    endtask

    // ---------------- 6a: output-register latency ----------------
    task automatic test_latency();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); w_idle();
            w_model[i] = {32'hA5A50000 | 32'(i), 32'h5A5A0000 | 32'(i)};
            w_wren_a = 1'b1; w_address_a = 10'(i); w_data_a = w_model[i];
        end
        @(negedge clk); w_idle();
        w_rden_a = 1'b1; w_address_a = 10'h003; w_rden_b = 1'b1; w_address_b = 10'h006;
        @(negedge clk); w_idle();
        #1;
        checks++; if (w_valid_a !== 1'b0 || w_valid_b !== 1'b0) begin errors++; $display("FAIL lat_early got=%b%b exp=00", w_valid_a, w_valid_b); end
        @(negedge clk); w_idle();
        #1;
        checks++; if (w_valid_a !== 1'b1 || w_out_a !== w_model[3]) begin errors++; $display("FAIL lat_a got=%h v=%b exp=%h", w_out_a, w_valid_a, w_model[3]); end
        checks++; if (w_valid_b !== 1'b1 || w_out_b !== w_model[6]) begin errors++; $display("FAIL lat_b got=%h v=%b exp=%h", w_out_b, w_valid_b, w_model[6]); end
        $display("[lat] read 3/6 at +2 cycles -> %h / %h", w_out_a, w_out_b);
        @(negedge clk); w_idle();
        #1;
        checks++; if (w_valid_a !== 1'b0 || w_out_a !== w_model[3]) begin errors++; $display("FAIL lat_hold got=%h v=%b exp=%h", w_out_a, w_valid_a, w_model[3]); end
        w_last_a = w_model[3];
        w_last_b = w_model[6];
    endtask

    // ---------------- 6b: random traffic vs write-first model ----------------
    task automatic test_random();
        logic        exp_v_a [RN];
        logic        exp_v_b [RN];
        logic [63:0] exp_d_a [RN];
        logic [63:0] exp_d_b [RN];
        logic        coll_exp, prev_set, prev_clr, ev_a, ev_b;
        logic [2:0]  ia, ib;
        coll_exp = 1'b0; prev_set = 1'b0; prev_clr = 1'b0;
        for (int k = 0; k < RN + 2; k++) begin
            @(negedge clk); w_idle();
            coll_exp = prev_set | (coll_exp & ~prev_clr);
            if (k < RN) begin
                w_address_a = 10'($urandom_range(0, 7));
                w_address_b = 10'($urandom_range(0, 7));
                w_wren_a = 1'($urandom_range(0, 1));
                w_wren_b = 1'($urandom_range(0, 1));
                w_rden_a = 1'($urandom_range(0, 1));
                w_rden_b = 1'($urandom_range(0, 1));
                w_clear_collision = ($urandom_range(0, 5) == 0);
                w_data_a = {$urandom, $urandom};
                w_data_b = {$urandom, $urandom};
                ia = w_address_a[2:0];
                ib = w_address_b[2:0];
                exp_v_a[k] = w_rden_a;
                exp_v_b[k] = w_rden_b;
                if (w_wren_a) exp_d_a[k] = w_data_a;
                else if (w_wren_b && ia == ib) exp_d_a[k] = w_data_b;
                else exp_d_a[k] = w_model[ia];
                if (w_wren_a && ia == ib) exp_d_b[k] = w_data_a;
                else if (w_wren_b) exp_d_b[k] = w_data_b;
                else exp_d_b[k] = w_model[ib];
                if (w_wren_b && !(w_wren_a && ia == ib)) w_model[ib] = w_data_b;
                if (w_wren_a) w_model[ia] = w_data_a;
                prev_set = w_wren_a & w_wren_b & (ia == ib);
                prev_clr = w_clear_collision;
            end else begin
                prev_set = 1'b0;
                prev_clr = 1'b0;
            end
            #1;
            ev_a = (k >= 2) ? exp_v_a[k - 2] : 1'b0;
            ev_b = (k >= 2) ? exp_v_b[k - 2] : 1'b0;
            if (ev_a) w_last_a = exp_d_a[k - 2];
            if (ev_b) w_last_b = exp_d_b[k - 2];
            checks++; if (w_valid_a !== ev_a || w_out_a !== w_last_a) begin errors++; $display("FAIL rnd_a cyc%0d got=%h v=%b exp=%h v=%b", k, w_out_a, w_valid_a, w_last_a, ev_a); end
            checks++; if (w_valid_b !== ev_b || w_out_b !== w_last_b) begin errors++; $display("FAIL rnd_b cyc%0d got=%h v=%b exp=%h v=%b", k, w_out_b, w_valid_b, w_last_b, ev_b); end
            checks++; if (w_collision !== coll_exp) begin errors++; $display("FAIL rnd_coll cyc%0d got=%b exp=%b", k, w_collision, coll_exp); end
            $display("[rnd] cyc %0d A v=%b %h B v=%b %h coll=%b", k, w_valid_a, w_out_a, w_valid_b, w_out_b, w_collision);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; w_reset = 1'b1;
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
        w_address_a = '0; w_address_b = '0; w_data_a = '0; w_data_b = '0;
        w_last_a = '0; w_last_b = '0;
        idle(); w_idle();
        repeat (3) @(negedge clk);
        reset = 1'b0; w_reset = 1'b0;
        test_reset();
        test_hold();
        test_forward();
        test_collision();
        test_banking();
        test_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
